bcd_tick_counter: RTL
=====================

Name: bcd_tick_counter

Overview:
Downstream consumer of clock_divider output. Samples the divided clock in the fast clock domain, converts each rising edge into a single-cycle count enable, and drives a DIGITS-wide BCD up/down counter with synchronous load and wrap indication. Its BCD outputs feed the display/segment stage. The divided clock is never used as a clock; the whole block runs on one fast clock.

Parameters:
DIGITS, 4, number of BCD digits; count width is 4*DIGITS.

Ports:
clk_in  input  1  fast system clock; the same clock that drives clock_divider.
rst  input  1  reset; asynchronous, active-high.
slow_clk  input  1  clock_divider clk_out, registered in the clk_in domain; used as data only.
en  input  1  count enable; ticks arriving while low are discarded.
up_dn  input  1  1 = count up, 0 = count down; sampled on the tick cycle.
load  input  1  synchronous load strobe.
load_val  input  4*DIGITS  BCD value to load; digit 0 is bits [3:0].
count  output  4*DIGITS  current BCD count; digit 0 is least significant.
tick  output  1  registered copy of the internal enable pulse, for chaining and debug.
wrap  output  1  one-cycle pulse on 9..9->0..0 (up) or 0..0->9..9 (down).

Behaviour:
- Reset (async assert, released synchronously by the caller): count=0, tick=0, wrap=0, slow_q=1. slow_q resets high so that slow_clk already high at reset release does not produce a spurious tick.
- Edge detect: slow_q <= slow_clk every cycle. Internal edge = slow_clk & ~slow_q, combinational and exactly one clk_in cycle per slow_clk rising edge. Falling edges are ignored.
- Step = edge & en & ~load.
- Priority per cycle, highest first: load, then step, then hold.
- Load: count <= load_val with per-digit clamping; any digit greater than 9 is stored as 9. wrap is 0 on a load cycle. A tick coinciding with load is dropped, not deferred.
- Step up: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. If every digit is 9, count becomes all 0 and wrap=1 on the next cycle.
- Step down: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. If every digit is 0, count becomes all 9 and wrap=1.
- Latency: on an edge cycle (posedge k), count updates at posedge k. The new value is visible from cycle k+1. tick and wrap are registered, high for cycle k+1 only.
- No step: count holds, tick=0, wrap=0.
- en low: edges are lost; there is no queued or pending tick when en returns high.
- up_dn changes between ticks take effect on the next tick. Direction is never latched.
- Reset mid-operation: immediate return to reset values. Any in-flight tick or wrap pulse is lost.
- count is always valid BCD; no digit ever exceeds 9.

Decomposition:
- Package bcd_pkg: BCD_MAX = 4'd9, BCD_MIN = 4'd0, BCD_W = 4, and a function that clamps a nibble to 9.
- Sub-module bcd_digit: one registered digit. Ports: clk_in, rst, load, load_digit, step_in, up_dn. Outputs: digit, carry_out. carry_out is combinational: step_in & up & digit==9, or step_in & down & digit==0. Instantiate DIGITS times in a generate chain: step_in of digit i+1 is carry_out of digit i; digit 0 takes step.
- wrap = carry_out of the top digit, registered.
- Edge detector and priority logic stay in the top level.

Test Plan:
- Reset with slow_clk held at 1, then release; hold slow_clk at 1 for 10 cycles -> count=0000, tick never asserts; the first later 0->1 edge gives count=0001.
- en=1, up_dn=1, 12 slow_clk rising edges, each slow_clk level held 4 cycles -> count=0012, exactly 12 single-cycle tick pulses, wrap=0 throughout.
- load_val=0x9998, load 1 cycle, then 2 up edges -> count 9999 then 0000; wrap high exactly one cycle, coincident with tick after the second edge.
- load_val=0x0000, up_dn=0, 1 edge -> count=9999, wrap=1 for one cycle. Then load_val=0x3AF7 -> count=3997 (clamped).
- Assert load on the same cycle as an edge, load_val=0x0050 -> count=0050 (not 0051), tick=0. Separately, an edge with en=0 -> count unchanged and not applied when en later rises.
- Assert rst asynchronously mid-run at count=0437 between clock edges -> count=0000, tick=0, wrap=0 immediately, before the next clk_in edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD constants and the nibble clamp used on load.
package bcd_pkg;
   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
   localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

   function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nib);
      return (nib > BCD_MAX) ? BCD_MAX : nib;
   endfunction
endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with up/down step and a combinational carry/borrow.
module bcd_digit
   import bcd_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst,
   input  logic             load,
   input  logic [BCD_W-1:0] load_digit,
   input  logic             step_in,
   input  logic             up_dn,
   output logic [BCD_W-1:0] digit,
   output logic             carry_out
);

   assign carry_out = step_in & (up_dn ? (digit == BCD_MAX) : (digit == BCD_MIN));

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         digit <= BCD_MIN;
      end else if (load) begin
         digit <= bcd_clamp(load_digit);
      end else if (step_in) begin
         if (up_dn)
            digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
         else
            digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_tick_counter.sv
// BCD up/down counter stepped once per rising edge of a slow clock sampled as data.
module bcd_tick_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk_in,
   input  logic                      rst,
   input  logic                      slow_clk,
   input  logic                      en,
   input  logic                      up_dn,
   input  logic                      load,
   input  logic [BCD_W*DIGITS-1:0]   load_val,
   output logic [BCD_W*DIGITS-1:0]   count,
   output logic                      tick,
   output logic                      wrap
);

   logic              slow_q;
   logic              slow_rise;
   logic              step;
   logic [DIGITS:0]   carry;

   // slow_q resets high so a slow_clk already high at release is not an edge
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst)
         slow_q <= 1'b1;
      else
         slow_q <= slow_clk;
   end

   assign slow_rise = slow_clk & ~slow_q;
   assign step      = slow_rise & en & ~load;
   assign carry[0]  = step;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk_in     (clk_in),
         .rst        (rst),
         .load       (load),
         .load_digit (load_val[i*BCD_W +: BCD_W]),
         .step_in    (carry[i]),
         .up_dn      (up_dn),
         .digit      (count[i*BCD_W +: BCD_W]),
         .carry_out  (carry[i+1])
      );
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         tick <= 1'b0;
         wrap <= 1'b0;
      end else begin
         tick <= step;
         wrap <= carry[DIGITS];
      end
   end

endmodule
